// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide on operand magnitudes, one bit per cycle, with RISC-V corner cases.
module muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            stall_o
);

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic                   w_a_signed, w_b_signed, w_sa, w_sb;
  logic                   w_is_div, w_divz, w_ovf, w_early, w_accept, w_last;
  logic signed [XLEN-1:0] w_rs1_s, w_rs2_s;
  logic [XLEN-1:0]        w_mag_a, w_mag_b, w_spec_res;

  logic [2:0]             r_op;
  logic [XLEN-1:0]        r_opa, r_opb;
  logic                   r_neg_q, r_neg_r, r_special;
  logic [XLEN-1:0]        r_spec_res;
  logic [2*XLEN-1:0]      r_acc;
  logic [XLEN-1:0]        r_quot, r_rem;
  logic [CW-1:0]          r_count;
  logic [XLEN-1:0]        r_result;

  logic [XLEN:0]          w_sum;
  logic [2*XLEN-1:0]      w_acc_nxt;
  logic [XLEN:0]          w_shift, w_trial;
  logic [XLEN-1:0]        w_quot_nxt, w_rem_nxt;

  // Sign fix-up of the magnitude results and selection of the requested half/part.
  function automatic logic [XLEN-1:0] f_result(
    input logic [2:0]        op,
    input logic              neg_q,
    input logic              neg_r,
    input logic [2*XLEN-1:0] prod,
    input logic [XLEN-1:0]   quot,
    input logic [XLEN-1:0]   rem
  );
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   res;
    p = neg_q ? -prod : prod;
    if (!op[2])
      res = (op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    else if (!op[1])
      res = neg_q ? -quot : quot;
    else
      res = neg_r ? -rem : rem;
    return res;
  endfunction

  // Operand decode at accept: signedness per funct3, magnitudes, corner cases.
  always_comb begin
    w_rs1_s    = rs1_i;
    w_rs2_s    = rs2_i;
    w_is_div   = op_i[2];
    w_a_signed = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
    w_b_signed = op_i[2] ? ~op_i[0] : ~op_i[1];
    w_sa       = w_a_signed & (w_rs1_s < 0);
    w_sb       = w_b_signed & (w_rs2_s < 0);
    w_mag_a    = w_sa ? -rs1_i : rs1_i;
    w_mag_b    = w_sb ? -rs2_i : rs2_i;
    w_divz     = w_is_div & (rs2_i == '0);
    w_ovf      = w_is_div & ~op_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);
    w_spec_res = w_divz ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);
    w_accept   = (r_state == S_IDLE) & start_i & ~flush_i;
    w_early    = EARLY_OUT & (w_divz | w_ovf);
    w_last     = (r_count == LAST);
  end

  // One iteration step: multiply adds the multiplicand on the low multiplier bit and
  // shifts right; divide shifts the next dividend bit into the partial remainder.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opa} : '0);
    w_acc_nxt  = {w_sum, r_acc[XLEN-1:1]};
    w_shift    = {r_rem, r_quot[XLEN-1]};
    w_trial    = w_shift - {1'b0, r_opb};
    w_rem_nxt  = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
    w_quot_nxt = {r_quot[XLEN-2:0], ~w_trial[XLEN]};
  end

  always_ff @(posedge clk_i) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_early ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_op       <= '0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_acc      <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_count    <= '0;
      r_result   <= '0;
    end else if (w_accept) begin
      r_op       <= op_i;
      r_opa      <= w_mag_a;
      r_opb      <= w_mag_b;
      r_neg_q    <= w_sa ^ w_sb;
      r_neg_r    <= w_sa;
      r_special  <= w_divz | w_ovf;
      r_spec_res <= w_spec_res;
      r_acc      <= {{XLEN{1'b0}}, w_mag_b};
      r_quot     <= w_mag_a;
      r_rem      <= '0;
      r_count    <= '0;
      if (w_early) r_result <= w_spec_res;
    end else if ((r_state == S_CALC) && !flush_i) begin
      r_acc  <= w_acc_nxt;
      r_quot <= w_quot_nxt;
      r_rem  <= w_rem_nxt;
      if (w_last)
        r_result <= r_special ? r_spec_res
                              : f_result(r_op, r_neg_q, r_neg_r, w_acc_nxt, w_quot_nxt, w_rem_nxt);
      else
        r_count <= r_count + 1'b1;
    end
  end

  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = (r_state == S_DONE);
  assign result_o = r_result;
  assign stall_o  = start_i & ~done_o;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M cases, randomized ops against a plain-arithmetic
// model, flush/reset/back-to-back scenarios, and a 16-bit instance without early-out.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s32, f32, busy32, done32, stall32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        s16, f16, busy16, done16, stall16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, res16;

  int total = 0;
  int bad   = 0;

  muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut32 (
    .clk_i(clk), .reset(reset), .start_i(s32), .op_i(op32), .rs1_i(a32), .rs2_i(b32),
    .flush_i(f32), .busy_o(busy32), .done_o(done32), .result_o(res32), .stall_o(stall32));

  muldiv_unit #(.XLEN(16), .EARLY_OUT(1'b0)) u_dut16 (
    .clk_i(clk), .reset(reset), .start_i(s16), .op_i(op16), .rs1_i(a16), .rs2_i(b16),
    .flush_i(f16), .busy_o(busy16), .done_o(done16), .result_o(res16), .stall_o(stall16));

  localparam int ND = 14;
  logic [2:0]  d_op  [ND] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
  logic [31:0] d_a   [ND] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'd5};
  logic [31:0] d_b   [ND] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
  logic [31:0] d_exp [ND] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                              32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                              32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd5};
  int          d_lat [ND] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 1, 1};

  // Reference: full-width two's-complement arithmetic on sign/zero-extended operands.
  function automatic logic [31:0] ref_model(input int w, input logic [2:0] op,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] mask, ax, bx, p;
    longint      q, r;
    bit          as, bs;
    mask = (64'd1 << w) - 64'd1;
    as = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    bs = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    ax = {32'h0, a} & mask;
    bx = {32'h0, b} & mask;
    if (as && a[w-1]) ax = ax | ~mask;
    if (bs && b[w-1]) bx = bx | ~mask;
    if (op < 3'd4) begin
      p = ax * bx;
      if (op != 3'd0) p = p >> w;
      return 32'(p & mask);
    end
    if (bx == 64'd0) begin
      q = -1;
      r = longint'(ax);
    end else begin
      q = longint'(ax) / longint'(bx);
      r = longint'(ax) % longint'(bx);
    end
    return ((op == 3'd4) || (op == 3'd5)) ? 32'(q & mask) : 32'(r & mask);
  endfunction

  function automatic int exp_lat(input int w, input bit eo, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask, msb;
    bit          special;
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
    msb  = 32'd1 << (w - 1);
    special = op[2] && (((b & mask) == 32'd0) ||
              (!op[0] && ((a & mask) == msb) && ((b & mask) == mask)));
    return (eo && special) ? 1 : w + 1;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return mask;
      3:       return 32'd1 << (w - 1);
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom & mask;
    endcase
  endfunction

  // Issues one op, holds start until done (as the stalled pipeline would) and scrambles
  // the operand inputs while the op is in flight.
  task automatic issue(input bit w16, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int lat,
                       output bit stall_ok);
    bit found;
    found = 1'b0; res = '0; lat = 0; stall_ok = 1'b1;
    @(negedge clk);
    if (w16) begin s16 = 1'b1; op16 = op; a16 = a[15:0]; b16 = b[15:0]; end
    else     begin s32 = 1'b1; op32 = op; a32 = a; b32 = b; end
    @(posedge clk);
    while (!found && lat < 200) begin
      @(negedge clk);
      lat++;
      if (w16 ? done16 : done32) begin
        found = 1'b1;
        res = w16 ? {16'h0, res16} : res32;
        if (w16 ? stall16 : stall32) stall_ok = 1'b0;
      end else begin
        if (!(w16 ? stall16 : stall32)) stall_ok = 1'b0;
        a32 = $urandom; b32 = $urandom; a16 = 16'($urandom); b16 = 16'($urandom);
      end
    end
    s32 = 1'b0; s16 = 1'b0;
    if (!found) lat = -1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    s32 = 0; f32 = 0; op32 = 0; a32 = 0; b32 = 0;
    s16 = 0; f16 = 0; op16 = 0; a16 = 0; b16 = 0;
    repeat (3) @(negedge clk);
    total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy32); end
    total++; if (done32 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done32); end
    total++; if (res32 !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", res32); end
    total++; if (stall32 !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall32); end
    total++; if (busy16 !== 1'b0 || res16 !== 16'd0)
      begin bad++; $display("FAIL reset16 busy=%b result=%h exp 0/0", busy16, res16); end
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] r; int l; bit sok;
    for (int i = 0; i < ND; i++) begin
      issue(1'b0, d_op[i], d_a[i], d_b[i], r, l, sok);
      total++; if (r !== d_exp[i]) begin bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, d_exp[i]); end
      total++; if (l != d_lat[i]) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, l, d_lat[i]); end
      total++; if (!sok) begin bad++; $display("FAIL dir%0d_stall got=bad exp=high-until-done", i); end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b, r, e; logic [2:0] op; int l, el; bit sok;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom); a = pick(32); b = pick(32);
      e = ref_model(32, op, a, b); el = exp_lat(32, 1'b1, op, a, b);
      issue(1'b0, op, a, b, r, l, sok);
      total++; if (r !== e) begin bad++; $display("FAIL rnd%0d op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, r, e); end
      total++; if (l != el) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, l, el); end
      total++; if (!sok) begin bad++; $display("FAIL rnd%0d_stall got=bad exp=high-until-done", i); end
    end
  endtask

  task automatic test_flush;
    logic [31:0] r; int l; bit sok, seen;
    issue(1'b0, 3'd0, 32'd6, 32'd7, r, l, sok);
    total++; if (r !== 32'd42) begin bad++; $display("FAIL flush_pre got=%h exp=%h", r, 32'd42); end
    @(negedge clk); s32 = 1'b1; op32 = 3'd0; a32 = 32'd123; b32 = 32'd456;
    @(posedge clk);
    repeat (11) @(negedge clk);
    total++; if (busy32 !== 1'b1) begin bad++; $display("FAIL flush_inflight_busy got=%b exp=1", busy32); end
    f32 = 1'b1; s32 = 1'b0;
    @(negedge clk);
    f32 = 1'b0;
    total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy32); end
    total++; if (done32 !== 1'b0) begin bad++; $display("FAIL flush_done got=%b exp=0", done32); end
    total++; if (res32 !== 32'd42) begin bad++; $display("FAIL flush_result got=%h exp=%h", res32, 32'd42); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done32) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL flush_no_done got=done exp=none"); end
    issue(1'b0, 3'd0, 32'd3, 32'd4, r, l, sok);
    total++; if (r !== 32'd12) begin bad++; $display("FAIL flush_post got=%h exp=%h", r, 32'd12); end
    total++; if (l != 33) begin bad++; $display("FAIL flush_post_latency got=%0d exp=33", l); end
  endtask

  task automatic test_flush_idle;
    bit seen;
    @(negedge clk); s32 = 1'b1; f32 = 1'b1; op32 = 3'd0; a32 = 32'd2; b32 = 32'd3;
    @(negedge clk);
    total++; if (busy32 !== 1'b0) begin bad++; $display("FAIL flush_idle_busy got=%b exp=0", busy32); end
    s32 = 1'b0; f32 = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done32 || busy32) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL flush_idle_activity got=active exp=idle"); end
    total++; if (res32 !== 32'd12) begin bad++; $display("FAIL flush_idle_result got=%h exp=%h", res32, 32'd12); end
  endtask

  task automatic test_flush_done;
    int n; bit found;
    @(negedge clk); s32 = 1'b1; op32 = 3'd5; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk);
    n = 0; found = 1'b0;
    while (!found && n < 200) begin @(negedge clk); n++; if (done32) found = 1'b1; end
    total++; if (!found) begin bad++; $display("FAIL flush_done_timeout got=none exp=done"); end
    f32 = 1'b1; s32 = 1'b0;
    #1;
    total++; if (done32 !== 1'b1) begin bad++; $display("FAIL flush_done_pulse got=%b exp=1", done32); end
    @(negedge clk);
    f32 = 1'b0;
    total++; if (busy32 !== 1'b0 || res32 !== 32'd14)
      begin bad++; $display("FAIL flush_done_after busy=%b result=%h exp 0/%h", busy32, res32, 32'd14); end
  endtask

  task automatic test_back_to_back;
    int n; bit found;
    @(negedge clk); s32 = 1'b1; op32 = 3'd0; a32 = 32'd5; b32 = 32'd5;
    @(posedge clk);
    n = 0; found = 1'b0;
    while (!found && n < 200) begin @(negedge clk); n++; if (done32) found = 1'b1; end
    total++; if (res32 !== 32'd25) begin bad++; $display("FAIL b2b_first got=%h exp=%h", res32, 32'd25); end
    op32 = 3'd5; a32 = 32'd1000; b32 = 32'd10;
    n = 0; found = 1'b0;
    while (!found && n < 200) begin @(negedge clk); n++; if (done32) found = 1'b1; end
    s32 = 1'b0;
    total++; if (n != 34) begin bad++; $display("FAIL b2b_gap got=%0d exp=34", n); end
    total++; if (res32 !== 32'd100) begin bad++; $display("FAIL b2b_second got=%h exp=%h", res32, 32'd100); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; int l; bit sok, seen;
    issue(1'b0, 3'd0, 32'd9, 32'd9, r, l, sok);
    total++; if (r !== 32'd81) begin bad++; $display("FAIL rstmid_pre got=%h exp=%h", r, 32'd81); end
    @(negedge clk); s32 = 1'b1; op32 = 3'd4; a32 = 32'd1000; b32 = 32'd3;
    @(posedge clk);
    repeat (5) @(negedge clk);
    reset = 1'b1; s32 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    total++; if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'd0)
      begin bad++; $display("FAIL rstmid busy=%b done=%b result=%h exp 0/0/0", busy32, done32, res32); end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (done32) seen = 1'b1; end
    total++; if (seen) begin bad++; $display("FAIL rstmid_no_done got=done exp=none"); end
  endtask

  task automatic test_xlen16;
    logic [31:0] a, b, r, e; logic [2:0] op; int l; bit sok;
    issue(1'b1, 3'd5, 32'h0000FFFF, 32'd3, r, l, sok);
    total++; if (r !== 32'h5555) begin bad++; $display("FAIL x16_divu got=%h exp=%h", r, 32'h5555); end
    total++; if (l != 17) begin bad++; $display("FAIL x16_divu_latency got=%0d exp=17", l); end
    issue(1'b1, 3'd4, 32'd5, 32'd0, r, l, sok);
    total++; if (r !== 32'hFFFF || l != 17)
      begin bad++; $display("FAIL x16_divz got=%h/%0d exp=ffff/17", r, l); end
    issue(1'b1, 3'd6, 32'h8000, 32'hFFFF, r, l, sok);
    total++; if (r !== 32'd0 || l != 17)
      begin bad++; $display("FAIL x16_ovf_rem got=%h/%0d exp=0/17", r, l); end
    for (int i = 0; i < 20; i++) begin
      op = 3'($urandom); a = pick(16); b = pick(16);
      e = ref_model(16, op, a, b);
      issue(1'b1, op, a, b, r, l, sok);
      total++; if (r !== e || l != exp_lat(16, 1'b0, op, a, b) || !sok)
        begin bad++; $display("FAIL x16_rnd%0d op=%0d a=%h b=%h got=%h/%0d exp=%h/17", i, op, a, b, r, l, e); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_flush;
    test_flush_idle;
    test_flush_done;
    test_back_to_back;
    test_reset_mid;
    test_xlen16;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
